// File: rtl/vector_logic_pkg.sv
// Shared definitions for vector_logic_pipe: operation encodings and the
// bitwise operation function used when stage 0 loads.
package vector_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } vl_op_e;

  // Widest operand the helper handles; callers zero-extend and truncate back.
  localparam int VL_MAX_WIDTH = 1024;

  function automatic logic [VL_MAX_WIDTH-1:0] vl_apply(
    input vl_op_e                  op,
    input logic [VL_MAX_WIDTH-1:0] a,
    input logic [VL_MAX_WIDTH-1:0] b
  );
    logic [VL_MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_logic_stage.sv
// One valid/data register slice of the pipeline. A load wins over a drain so
// that a stage handing its item on while receiving a new one stays valid.
module vector_logic_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_logic_pipe.sv
// WIDTH-bit bitwise logic unit behind a LATENCY-stage valid/ready pipeline
// with bubble collapsing and a saturating completed-result counter.
module vector_logic_pipe
  import vector_logic_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     c,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] result_count
);

  logic [LATENCY-1:0] valid;
  logic [LATENCY-1:0] can_load;
  logic [LATENCY-1:0] load;
  logic [LATENCY-1:0] drain;
  logic [WIDTH-1:0]   data    [LATENCY];
  logic [WIDTH-1:0]   stage_d [LATENCY];
  logic               chain;

  // Ready ripples back from out_ready; an empty stage always accepts.
  always_comb begin
    can_load = '0;
    chain    = ~valid[LATENCY-1] | out_ready;
    can_load[LATENCY-1] = chain;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      chain       = ~valid[k] | chain;
      can_load[k] = chain;
    end
  end

  assign in_ready = can_load[0] & ~rst;

  always_comb begin
    load       = '0;
    drain      = '0;
    load[0]    = in_valid & in_ready;
    stage_d[0] = WIDTH'(vl_apply(vl_op_e'(op), VL_MAX_WIDTH'(a), VL_MAX_WIDTH'(b)));
    for (int k = 1; k < LATENCY; k++) begin
      load[k]    = valid[k-1] & can_load[k];
      stage_d[k] = data[k-1];
    end
    for (int k = 0; k < LATENCY - 1; k++) begin
      drain[k] = valid[k] & can_load[k+1];
    end
    drain[LATENCY-1] = valid[LATENCY-1] & out_ready;
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    vector_logic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .drain (drain[k]),
      .d     (stage_d[k]),
      .valid (valid[k]),
      .data  (data[k])
    );
  end

  assign out_valid = valid[LATENCY-1];
  assign c         = data[LATENCY-1];

  // Clear beats a simultaneous completion; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_count <= '0;
    end else if (cnt_clr) begin
      result_count <= '0;
    end else if (out_valid && out_ready && (result_count != {CNT_WIDTH{1'b1}})) begin
      result_count <= result_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_vector_logic_pipe.sv
// Directed and randomised checks of vector_logic_pipe at WIDTH=8, LATENCY=2,
// CNT_WIDTH=4 against hand-computed values and a small FIFO reference model.
module tb_vector_logic_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] c;
  logic       cnt_clr = 1'b0;
  logic [3:0] result_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_logic_pipe #(.WIDTH(8), .LATENCY(2), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .c            (c),
    .cnt_clr      (cnt_clr),
    .result_count (result_count)
  );

  function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (c !== 8'h00) begin errors++; $display("[TB] FAIL reset_c got=%h want=00", c); end
    checks++;
    if (result_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d want=0", result_count); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic_ops();
    logic [1:0] ops [4];
    logic [7:0] exp [4];
    ops = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    out_ready = 1'b1;
    a = 8'hF0;
    b = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        op = ops[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || c !== exp[i-1]) begin
          errors++;
          $display("[TB] FAIL basic_op%0d got valid=%b c=%h want valid=1 c=%h", i - 1, out_valid, c, exp[i-1]);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained got=%b want=0", out_valid); end
    checks++;
    if (result_count !== 4'd4) begin errors++; $display("[TB] FAIL basic_count got=%0d want=4", result_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    op = 2'b00;
    in_valid = 1'b1; a = 8'hFF; b = 8'h0F;
    step();
    a = 8'hAA; b = 8'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_accept got=%b want=1", in_ready); end
    step();
    a = 8'h55; b = 8'hF0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_in_ready got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || c !== 8'h0F) begin errors++; $display("[TB] FAIL bp_hold0 got valid=%b c=%h want valid=1 c=0f", out_valid, c); end
    step();
    checks++;
    if (out_valid !== 1'b1 || c !== 8'h0F) begin errors++; $display("[TB] FAIL bp_hold1 got valid=%b c=%h want valid=1 c=0f", out_valid, c); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_pass_through got=%b want=1", in_ready); end
    step();
    checks++;
    if (c !== 8'hAA) begin errors++; $display("[TB] FAIL bp_item1 got=%h want=aa", c); end
    a = 8'h33; b = 8'h3C;
    step();
    in_valid = 1'b0;
    checks++;
    if (c !== 8'h50) begin errors++; $display("[TB] FAIL bp_item2 got=%h want=50", c); end
    step();
    checks++;
    if (out_valid !== 1'b1 || c !== 8'h30) begin errors++; $display("[TB] FAIL bp_item3 got valid=%b c=%h want valid=1 c=30", out_valid, c); end
    step();
    checks++;
    if (out_valid !== 1'b0 || result_count !== 4'd8) begin
      errors++; $display("[TB] FAIL bp_end got valid=%b count=%0d want valid=0 count=8", out_valid, result_count);
    end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 2'b01; a = 8'h0F; b = 8'hF0;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || c !== 8'hFF) begin errors++; $display("[TB] FAIL bubble_first got valid=%b c=%h want valid=1 c=ff", out_valid, c); end
    in_valid = 1'b1; op = 2'b10; a = 8'h12; b = 8'h34;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bubble_accept got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || c !== 8'hFF) begin errors++; $display("[TB] FAIL bubble_full got ready=%b c=%h want ready=0 c=ff", in_ready, c); end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || c !== 8'h26) begin errors++; $display("[TB] FAIL bubble_second got valid=%b c=%h want valid=1 c=26", out_valid, c); end
    step();
    checks++;
    if (out_valid !== 1'b0 || result_count !== 4'd10) begin
      errors++; $display("[TB] FAIL bubble_end got valid=%b count=%0d want valid=0 count=10", out_valid, result_count);
    end
  endtask

  task automatic test_counter();
    out_ready = 1'b1; op = 2'b00; a = 8'h01; b = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    in_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (result_count !== 4'd15) begin errors++; $display("[TB] FAIL count_saturate got=%0d want=15", result_count); end
    in_valid = 1'b1;
    step();
    step();
    cnt_clr = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_handshake_valid got=%b want=1", out_valid); end
    step();
    cnt_clr = 1'b0;
    checks++;
    if (result_count !== 4'd0) begin errors++; $display("[TB] FAIL count_clear got=%0d want=0", result_count); end
    step();
    checks++;
    if (result_count !== 4'd1) begin errors++; $display("[TB] FAIL count_after_clear got=%0d want=1", result_count); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; op = 2'b01; a = 8'h11; b = 8'h22;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || c !== 8'h00 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset got valid=%b c=%h ready=%b want 0/00/0", out_valid, c, in_ready);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || result_count !== 4'd0) begin
      errors++; $display("[TB] FAIL midreset_stale got valid=%b count=%0d want 0/0", out_valid, result_count);
    end
    in_valid = 1'b1; op = 2'b11; a = 8'hF0; b = 8'h3C;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || c !== 8'hCF) begin
      errors++; $display("[TB] FAIL midreset_first got valid=%b c=%h want valid=1 c=cf", out_valid, c);
    end
    step();
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q [$];
    logic [7:0] want;
    int sent = 0;
    int got  = 0;
    int cycles = 0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    while (got < 1000 && cycles < 20000) begin
      in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(op, a, b));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra got c=%h want no output", c);
        end else begin
          want = exp_q.pop_front();
          if (c !== want) begin errors++; $display("[TB] FAIL rand_item%0d got=%h want=%h", got, c, want); end
        end
        got++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 1000) begin errors++; $display("[TB] FAIL rand_timeout got=%0d want=1000 results", got); end
    checks++;
    if (result_count !== 4'd15) begin errors++; $display("[TB] FAIL rand_count got=%0d want=15", result_count); end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_backpressure();
    test_bubble_collapse();
    test_counter();
    test_reset_midstream();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
